// File: rtl/pci_arbiter_if.sv
// pci_arbiter_if -- PCI arbitration bus bundle.
//
// Groups the masters' request lines, the observed FRAME_/IRDY_ bus state and
// the arbiter's grant/status outputs.
//   modport master : the arbiter side (samples REQ_/FRAME_/IRDY_, drives GNT_
//                    and status)
//   modport slave  : the bus-agent side (drives REQ_/FRAME_/IRDY_, observes
//                    GNT_ and status)
// Signals (all active-low where the name ends in '_'):
//   REQ_[3:0]    bus requests from masters 0..3
//   FRAME_       PCI FRAME_ as seen on the bus
//   IRDY_        PCI IRDY_ as seen on the bus
//   GNT_[3:0]    grants, at most one low
//   owner[1:0]   index of the master granted / owning the bus
//   bus_busy     high while a master holds a grant or the bus
//   timeout_err  one-cycle pulse when a grant is revoked for FRAME_ timeout
interface pci_arbiter_if;
    logic [3:0] REQ_;
    logic       FRAME_;
    logic       IRDY_;
    logic [3:0] GNT_;
    logic [1:0] owner;
    logic       bus_busy;
    logic       timeout_err;

    modport master (
        input  REQ_, FRAME_, IRDY_,
        output GNT_, owner, bus_busy, timeout_err
    );

    modport slave (
        output REQ_, FRAME_, IRDY_,
        input  GNT_, owner, bus_busy, timeout_err
    );
endinterface

// File: rtl/pci_arbiter.sv
// pci_arbiter -- four-master round-robin PCI bus arbiter.
//
// Ports:
//   clk    single clock, all state changes on posedge
//   reset  asynchronous active-high reset, synchronous release
//   bus    pci_arbiter_if.master (REQ_, FRAME_, IRDY_ in; GNT_, owner,
//          bus_busy, timeout_err out)
// Parameter:
//   TIMEOUT_CYC  clocks a granted master has to assert FRAME_ (2..255)
// Build option:
//   PCI_ARB_TIMEOUT_EN  defined: grant is revoked after TIMEOUT_CYC clocks
//                       without FRAME_, with a timeout_err pulse.
//                       undefined: GRANT waits indefinitely, timeout_err = 0.
//
// state | meaning
// IDLE  | no grant; arbitrate when the bus is idle
// GRANT | one master granted, waiting for its FRAME_
// BUSY  | granted master owns the bus; wait for FRAME_/IRDY_ both high
// TURN  | one turnaround clock with all grants high
module pci_arbiter #(
    parameter int unsigned TIMEOUT_CYC = 16
) (
    input  logic           clk,
    input  logic           reset,
    pci_arbiter_if.master  bus
);

    generate
        if (TIMEOUT_CYC < 2 || TIMEOUT_CYC > 255) begin : g_bad_timeout
            $error("pci_arbiter: TIMEOUT_CYC must be within 2..255");
        end
    endgenerate

    typedef enum logic [1:0] {S_IDLE, S_GRANT, S_BUSY, S_TURN} state_t;

    state_t     r_state;
    logic [3:0] r_gnt;
    logic [1:0] r_owner;
    logic [1:0] r_last;
    logic       r_busy;

`ifdef PCI_ARB_TIMEOUT_EN
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYC - 1);
    logic [7:0] r_wait;
    logic       r_terr;
`endif

    logic       w_bus_idle;
    logic       w_owner_req;
    logic       w_found;
    logic [1:0] w_win;

    assign w_bus_idle  = bus.FRAME_ & bus.IRDY_;
    assign w_owner_req = ~bus.REQ_[r_owner];

    // Round-robin search starting one past the last bus owner; i = 4 wraps
    // back onto the last owner itself so a lone requester is never starved.
    always_comb begin
        w_found = 1'b0;
        w_win   = 2'd0;
        for (int i = 1; i <= 4; i++) begin
            if (!w_found && !bus.REQ_[2'(r_last + 2'(i))]) begin
                w_found = 1'b1;
                w_win   = 2'(r_last + 2'(i));
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_gnt   <= 4'hF;
            r_owner <= 2'd0;
            r_last  <= 2'd3;
            r_busy  <= 1'b0;
`ifdef PCI_ARB_TIMEOUT_EN
            r_wait  <= 8'd0;
            r_terr  <= 1'b0;
`endif
        end else begin
`ifdef PCI_ARB_TIMEOUT_EN
            r_terr <= 1'b0;
`endif
            case (r_state)
                S_IDLE: begin
                    if (w_found && w_bus_idle) begin
                        r_gnt   <= ~(4'b0001 << w_win);
                        r_owner <= w_win;
                        r_busy  <= 1'b1;
                        r_state <= S_GRANT;
`ifdef PCI_ARB_TIMEOUT_EN
                        r_wait  <= 8'd0;
`endif
                    end
                end
                S_GRANT: begin
                    // FRAME_ wins over withdrawal and timeout on the same edge.
                    if (!bus.FRAME_) begin
                        r_last  <= r_owner;
                        r_state <= S_BUSY;
                    end else if (!w_owner_req) begin
                        r_gnt   <= 4'hF;
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end
`ifdef PCI_ARB_TIMEOUT_EN
                    else if (r_wait == TO_LAST) begin
                        r_gnt   <= 4'hF;
                        r_terr  <= 1'b1;
                        r_last  <= r_owner;
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        r_wait  <= r_wait + 8'd1;
                    end
`endif
                end
                S_BUSY: begin
                    if (w_bus_idle) begin
                        r_gnt   <= 4'hF;
                        r_busy  <= 1'b0;
                        r_state <= S_TURN;
                    end else if (!w_owner_req) begin
                        // Early grant removal; the owner keeps the bus until idle.
                        r_gnt   <= 4'hF;
                    end
                end
                S_TURN: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_gnt   <= 4'hF;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.GNT_     = r_gnt;
    assign bus.owner    = r_owner;
    assign bus.bus_busy = r_busy;
`ifdef PCI_ARB_TIMEOUT_EN
    assign bus.timeout_err = r_terr;
`else
    assign bus.timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_pci_arbiter.sv
module tb_pci_arbiter;
    localparam int TO_CYC = 16;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   terr_count = 0;

    pci_arbiter_if bus ();

    pci_arbiter #(.TIMEOUT_CYC(TO_CYC)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    // Phases of bus ownership as seen by a protocol observer.
    typedef enum {P_FREE, P_OFFERED, P_TXN, P_GAP} phase_t;
    phase_t m_phase   = P_FREE;
    int     m_owner   = 0;
    int     m_last    = 3;
    bit     m_granted = 1'b0;
    int     m_waited  = 0;
    bit     m_terr    = 1'b0;

    function automatic int rr_pick(input logic [3:0] req_n, input int last);
        for (int k = 1; k <= 4; k++) begin
            if (req_n[(last + k) % 4] == 1'b0) return (last + k) % 4;
        end
        return -1;
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_phase = P_FREE; m_owner = 0; m_last = 3;
            m_granted = 1'b0; m_waited = 0; m_terr = 1'b0;
        end else begin
            bit idle;
            int w;
            idle   = bus.FRAME_ && bus.IRDY_;
            m_terr = 1'b0;
            case (m_phase)
                P_FREE: begin
                    w = rr_pick(bus.REQ_, m_last);
                    if (w >= 0 && idle) begin
                        m_owner = w; m_granted = 1'b1; m_waited = 0; m_phase = P_OFFERED;
                    end
                end
                P_OFFERED: begin
                    if (!bus.FRAME_) begin
                        m_last = m_owner; m_phase = P_TXN;
                    end else if (bus.REQ_[m_owner]) begin
                        m_granted = 1'b0; m_phase = P_FREE;
                    end
`ifdef PCI_ARB_TIMEOUT_EN
                    else if (m_waited + 1 >= TO_CYC) begin
                        m_granted = 1'b0; m_terr = 1'b1; m_last = m_owner; m_phase = P_FREE;
                    end else m_waited++;
`endif
                end
                P_TXN: begin
                    if (bus.REQ_[m_owner]) m_granted = 1'b0;
                    if (idle) begin m_granted = 1'b0; m_phase = P_GAP; end
                end
                P_GAP: m_phase = P_FREE;
            endcase
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        logic [3:0] exp_gnt;
        exp_gnt = m_granted ? 4'hF & ~(4'h1 << m_owner) : 4'hF;
        if (bus.timeout_err === 1'b1) terr_count++;
        checks++;
        assert ($countones(~bus.GNT_) <= 1 && !$isunknown(bus.GNT_)) else begin
            errors++;
            $display("FAIL gnt_onecold: GNT_=%b", bus.GNT_);
        end
        checks++;
        if (bus.GNT_ !== exp_gnt) begin
            errors++;
            $display("FAIL model_gnt t=%0t: GNT_=%b expected %b", $time, bus.GNT_, exp_gnt);
        end
        checks++;
        if (bus.owner !== 2'(m_owner)) begin
            errors++;
            $display("FAIL model_owner t=%0t: owner=%0d expected %0d", $time, bus.owner, m_owner);
        end
        checks++;
        if (bus.bus_busy !== (m_phase == P_OFFERED || m_phase == P_TXN)) begin
            errors++;
            $display("FAIL model_busy t=%0t: bus_busy=%b expected %b", $time, bus.bus_busy,
                     (m_phase == P_OFFERED || m_phase == P_TXN));
        end
        checks++;
        if (bus.timeout_err !== m_terr) begin
            errors++;
            $display("FAIL model_terr t=%0t: timeout_err=%b expected %b", $time, bus.timeout_err, m_terr);
        end
    end

    // ---------------- helpers ----------------
    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_grant(output int idx);
        int n;
        n = 0;
        while (bus.GNT_ === 4'hF && n < 30) begin tick(); n++; end
        idx = -1;
        for (int k = 0; k < 4; k++) if (bus.GNT_[k] === 1'b0) idx = k;
        checks++;
        if (idx < 0) begin
            errors++;
            $display("FAIL grant_wait: no grant after %0d cycles, GNT_=%b", n, bus.GNT_);
        end
    endtask

    // 3-clock FRAME_ transaction, then bus back to idle
    task automatic run_txn();
        bus.FRAME_ = 1'b0; bus.IRDY_ = 1'b1; tick();
        bus.IRDY_ = 1'b0; tick(2);
        bus.FRAME_ = 1'b1; tick();
        bus.IRDY_ = 1'b1; tick();
    endtask

    // ---------------- directed stimulus ----------------
    int g;
    int terr_base;
    int glen;
    int exp_rr [4] = '{0, 2, 0, 2};

    initial begin
        bus.REQ_ = 4'hF; bus.FRAME_ = 1'b1; bus.IRDY_ = 1'b1;
        tick(2);
        chk("reset_gnt", 32'(bus.GNT_), 32'hF);
        chk("reset_owner", 32'(bus.owner), 32'd0);
        chk("reset_busy", 32'(bus.bus_busy), 32'd0);
        reset = 1'b0;
        tick();

        // first arbitration favours master 0, one clock latency
        bus.REQ_ = 4'b0000;
        tick();
        chk("first_gnt", 32'(bus.GNT_), 32'b1110);
        chk("first_owner", 32'(bus.owner), 32'd0);
        bus.REQ_ = 4'hF;            // withdraw before FRAME_
        tick();
        chk("withdraw_gnt", 32'(bus.GNT_), 32'hF);
        tick();

        // masters 0 and 2 alternate
        bus.REQ_ = 4'b1010;
        for (int r = 0; r < 4; r++) begin
            wait_grant(g);
            chk($sformatf("rr_order%0d", r), 32'(g), 32'(exp_rr[r]));
            run_txn();
            chk($sformatf("rr_turn%0d", r), 32'(bus.GNT_), 32'hF);
        end
        bus.REQ_ = 4'hF;
        tick(3);

        // owner drops REQ_ mid-burst: grant removed, bus stays owned
        bus.REQ_ = 4'b1101;
        wait_grant(g);
        chk("early_rel_idx", 32'(g), 32'd1);
        bus.FRAME_ = 1'b0; tick();
        bus.REQ_ = 4'hF; tick();
        chk("early_rel_gnt", 32'(bus.GNT_), 32'hF);
        chk("early_rel_busy", 32'(bus.bus_busy), 32'd1);
        bus.FRAME_ = 1'b1; bus.IRDY_ = 1'b0; tick();
        bus.IRDY_ = 1'b1; tick(3);

        // REQ_ withdrawn on the FRAME_ edge
        bus.REQ_ = 4'b0111;
        wait_grant(g);
        chk("same_edge_idx", 32'(g), 32'd3);
        bus.FRAME_ = 1'b0; bus.IRDY_ = 1'b0; bus.REQ_ = 4'hF;
        tick();
        chk("same_edge_gnt", 32'(bus.GNT_), 32'b0111);
        chk("same_edge_busy", 32'(bus.bus_busy), 32'd1);
        chk("same_edge_terr", 32'(bus.timeout_err), 32'd0);
        tick();
        chk("same_edge_gnt2", 32'(bus.GNT_), 32'hF);
        bus.FRAME_ = 1'b1; bus.IRDY_ = 1'b1; tick(3);

        // FRAME_ never asserted
        bus.REQ_ = 4'b1001;
        wait_grant(g);
        chk("to_idx", 32'(g), 32'd1);
        terr_base = terr_count;
`ifdef PCI_ARB_TIMEOUT_EN
        glen = 0;
        while (bus.GNT_[1] === 1'b0 && glen < 40) begin glen++; tick(); end
        chk("to_grant_len", 32'(glen), 32'd16);
        chk("to_revoke_gnt", 32'(bus.GNT_), 32'hF);
        tick();
        wait_grant(g);
        chk("to_next_idx", 32'(g), 32'd2);
        chk("to_pulses", 32'(terr_count - terr_base), 32'd1);
`else
        tick(20);
        chk("to_hold_gnt", 32'(bus.GNT_), 32'b1101);
        bus.REQ_ = 4'b1011;
        tick();
        chk("to_release_gnt", 32'(bus.GNT_), 32'hF);
        wait_grant(g);
        chk("to_next_idx", 32'(g), 32'd2);
        chk("to_pulses", 32'(terr_count - terr_base), 32'd0);
`endif
        bus.REQ_ = 4'hF;
        tick(3);

        // async reset mid-burst
        bus.REQ_ = 4'b1110;
        wait_grant(g);
        bus.FRAME_ = 1'b0; bus.IRDY_ = 1'b0;
        tick(2);
        #2 reset = 1'b1;
        #1;
        chk("areset_gnt", 32'(bus.GNT_), 32'hF);
        chk("areset_owner", 32'(bus.owner), 32'd0);
        chk("areset_busy", 32'(bus.bus_busy), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        bus.FRAME_ = 1'b1; bus.IRDY_ = 1'b1; bus.REQ_ = 4'b0101;
        tick();
        chk("post_reset_gnt", 32'(bus.GNT_), 32'b1101);
        chk("post_reset_owner", 32'(bus.owner), 32'd1);
        bus.REQ_ = 4'hF;
        tick(3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/pci_arbiter.md
PCI_ARBITER -- requirements
Module: pci_arbiter

Interface
REQ-001 Parameter: TIMEOUT_CYC, 16, clocks a granted master has to assert FRAME_ before its grant is revoked; legal range 2..255.
REQ-002 Port: clk  in  1  single clock; all state changes on posedge.
REQ-003 Port: reset  in  1  asynchronous, active-high reset.
REQ-004 Port: REQ_  in  4  active-low bus requests from masters 0..3.
REQ-005 Port: FRAME_  in  1  active-low PCI FRAME_ as seen on the bus.
REQ-006 Port: IRDY_  in  1  active-low PCI IRDY_ as seen on the bus.
REQ-007 Port: GNT_  out  4  active-low grants; at most one bit low at any time.
REQ-008 Port: owner  out  2  index of the master currently granted or owning the bus.
REQ-009 Port: bus_busy  out  1  high while in state GRANT or BUSY.
REQ-010 Port: timeout_err  out  1  one-cycle pulse when a grant is revoked for a FRAME_ timeout.

Function
REQ-011 The bus is idle when FRAME_ and IRDY_ are both high.
REQ-012 The FSM has four states: IDLE, GRANT, BUSY, TURN; all outputs are registered.
REQ-013 Arbitration is round-robin: the search starts at last+1 mod 4, where last is the most recent master to own the bus, and the first low REQ_ bit wins.
REQ-014 IDLE: if any REQ_ bit is low and the bus is idle, the arbiter drives the winner's GNT_ low, sets owner to the winner and enters GRANT on the same edge; otherwise GNT_ stays 4'hF.
REQ-015 Grant latency: a REQ_ sampled low at edge N in IDLE gives a GNT_ low output after edge N, i.e. one clock.
REQ-016 GRANT: if FRAME_ is sampled low, the arbiter enters BUSY and sets last to owner.
REQ-017 GRANT: if the owner's REQ_ is sampled high and FRAME_ is high, the arbiter sets GNT_ to 4'hF and returns to IDLE; last is unchanged.
REQ-018 GRANT: the wait counter clears on entry and increments each cycle; when it reaches TIMEOUT_CYC-1 with FRAME_ still high, the arbiter sets GNT_ to 4'hF, pulses timeout_err, sets last to owner and returns to IDLE.
REQ-019 Simultaneous events in GRANT: FRAME_ low takes priority over both REQ_ withdrawal and timeout; no timeout_err is produced.
REQ-020 BUSY: GNT_ stays low while the owner's REQ_ is low; when the owner's REQ_ goes high, GNT_ goes to 4'hF on the next edge, and the arbiter stays in BUSY.
REQ-021 BUSY: when the bus is sampled idle, the arbiter enters TURN with GNT_ = 4'hF.
REQ-022 TURN: lasts exactly one clock with all grants high (turnaround), then moves to IDLE; REQ_ is ignored during TURN.
REQ-023 owner holds its value in IDLE and TURN, so it shows the last owner.
REQ-024 A REQ_ bit toggling for a master that is not the owner has no effect outside IDLE.
REQ-025 GNT_ is never low for more than one master, including on every transition edge.

Reset
REQ-026 While reset is high, the block forces: state IDLE, GNT_ = 4'hF, owner = 0, last = 3, wait counter = 0, timeout_err = 0, bus_busy = 0.
REQ-027 Reset takes effect asynchronously, including mid-transaction, and release is synchronous to clk.
REQ-028 The first arbitration after reset favours master 0.

Configuration
REQ-029 Macro PCI_ARB_TIMEOUT_EN defined: the wait counter and the REQ-018 timeout behaviour are present.
REQ-030 Macro PCI_ARB_TIMEOUT_EN undefined: no wait counter is built, GRANT waits indefinitely for FRAME_ or REQ_ withdrawal, and timeout_err is tied to 0.

Verification
REQ-031 Reset, then REQ_=4'b0000 with the bus idle -> GNT_=4'b1110 one clock later, owner=0.
REQ-032 Masters 0 and 2 request continuously, each running a 3-clock FRAME_ transaction -> grants alternate 0,2,0,2 with one TURN clock of GNT_=4'hF between them.
REQ-033 (TIMEOUT_EN, TIMEOUT_CYC=16) REQ_[1] low, FRAME_ never asserted -> GNT_[1] low for 16 clocks, then GNT_=4'hF and a single timeout_err pulse; a pending REQ_[2] is granted next.
REQ-034 REQ_[3] withdrawn in the same clock that FRAME_ falls -> state BUSY, no timeout_err, GNT_ high on the next edge.
REQ-035 reset asserted in BUSY mid-burst -> GNT_=4'hF immediately, without waiting for a clock edge; after release, REQ_=4'b0101 -> master 1 is granted.
REQ-036 Across all scenarios, an assertion checks GNT_ one-cold or all-high every cycle and checks that GNT_ changes only as described above.
